// File: rtl/sipo_rx_ctrl.sv
// Serial-in/parallel-out receive controller: captures MSB-first bits into a word,
// hands completed words to a one-entry valid/ready buffer, and flags dropped words.
module sipo_rx_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  continuous,
   input  logic                  abort,
   input  logic                  serial_in,
   input  logic                  serial_valid,
   input  logic                  out_ready,
   input  logic                  clear_overrun,
   output logic [DATA_WIDTH-1:0] parallel_out,
   output logic                  out_valid,
   output logic                  busy,
   output logic [CNT_W-1:0]      bit_count,
   output logic                  overrun
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  ovr_q, ovr_d;

   logic [DATA_WIDTH-1:0] next_word;
   logic                  bit_accept;
   logic                  word_done;
   logic                  buf_free;
   logic                  drop;

   assign next_word  = {shift_q[DATA_WIDTH-2:0], serial_in};
   assign bit_accept = (state_q == SHIFT) && serial_valid && !abort;
   assign word_done  = bit_accept && (cnt_q == LAST_BIT);
   // A same-cycle drain frees the buffer for the completing word.
   assign buf_free   = !valid_q || out_ready;
   assign drop       = word_done && !buf_free;

   // Frame sequencing: state, shift register and bit counter.
   always_comb begin
      // NOTE: every output of a combinational block is defaulted first so no path
      // leaves it unassigned; an unassigned path would infer a latch.
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = SHIFT;
               shift_d = '0;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_d = IDLE;
               shift_d = '0;
               cnt_d   = '0;
            end else if (serial_valid) begin
               shift_d = next_word;
               if (cnt_q == LAST_BIT) begin
                  cnt_d = '0;
                  if (!continuous) begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output buffer and sticky overrun; a drop outranks a same-cycle clear.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q && !out_ready;
      if (word_done && buf_free) begin
         data_d  = next_word;
         valid_d = 1'b1;
      end
      ovr_d = (ovr_q && !clear_overrun) || drop;
   end

   // NOTE: the shift register and output word are ordinary flops, not a memory
   // array, so they take the reset value like every other piece of state.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign parallel_out = data_q;
   assign out_valid    = valid_q;
   assign busy         = (state_q == SHIFT);
   assign bit_count    = cnt_q;
   assign overrun      = ovr_q;

endmodule

// File: doc/sipo_rx_ctrl.md
# sipo_rx_ctrl

Receive-side controller for the serial-in/parallel-out shift path. It sequences bit capture into a DATA_WIDTH-bit shift register and counts bits to word boundaries. Each completed word is handed to a one-entry output buffer with a valid/ready handshake. It sits between a serial bit source (strobed by `serial_valid`) and a parallel word consumer, and flags words lost to consumer backpressure.

## Interface
- `DATA_WIDTH`, default 8: bits per word; legal range 2 to 64.
- `CNT_W`, default `$clog2(DATA_WIDTH)`: width of the bit counter; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `start`  in  1  single-cycle request to begin a frame; sampled only in IDLE.
- `continuous`  in  1  1 = stay in SHIFT after each word; 0 = return to IDLE after one word. Sampled at word completion.
- `abort`  in  1  discard the partial word and return to IDLE.
- `serial_in`  in  1  serial data bit, MSB first.
- `serial_valid`  in  1  `serial_in` is a valid bit this cycle.
- `out_ready`  in  1  consumer accepts `parallel_out` this cycle.
- `clear_overrun`  in  1  clears the sticky `overrun` flag.
- `parallel_out`  out  DATA_WIDTH  completed word held in the output buffer.
- `out_valid`  out  1  `parallel_out` holds an unconsumed word.
- `busy`  out  1  FSM is in SHIFT.
- `bit_count`  out  CNT_W  bits captured in the current word, 0..DATA_WIDTH-1.
- `overrun`  out  1  sticky; a completed word was dropped.

## Operation
- The FSM has two states, IDLE and SHIFT.
- IDLE:
  - `start`=1 moves the FSM to SHIFT, clears the shift register and sets `bit_count`=0.
  - `serial_valid` is ignored in IDLE.
- SHIFT, on each cycle with `serial_valid`=1:
  - shift register <= {shift_reg[DATA_WIDTH-2:0], serial_in}.
  - `bit_count` increments.
- Word completion is a cycle with `serial_valid`=1 while `bit_count`=DATA_WIDTH-1. On that cycle:
  - The completed word is {shift_reg[DATA_WIDTH-2:0], serial_in}.
  - If the buffer is free, the word loads into `parallel_out` and `out_valid` is set. The buffer is free when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1 in the same cycle.
  - Otherwise the word is dropped, `overrun` is set, and `parallel_out` keeps the older word.
  - `bit_count` returns to 0.
  - If `continuous`=1 the FSM stays in SHIFT; otherwise it goes to IDLE.
- Handshake:
  - A transfer occurs on any edge where `out_valid`=1 and `out_ready`=1.
  - After a transfer, `out_valid` clears unless a new word loads on the same edge.
  - `parallel_out` is stable while `out_valid`=1 and no transfer occurs.
- `abort`=1 in SHIFT:
  - The FSM goes to IDLE, `bit_count`=0 and the partial word is discarded.
  - The output buffer, `out_valid` and `overrun` are unaffected.
- `overrun` stays set until a cycle with `clear_overrun`=1. If a drop and `clear_overrun` occur in the same cycle, set wins.

## Timing
- Reset values: FSM=IDLE, `busy`=0, `bit_count`=0, shift register=0, `parallel_out`=0, `out_valid`=0, `overrun`=0.
- Reset has priority over all other inputs. Reset asserted mid-word discards the word and clears any buffered word.
- `busy` rises on the edge that samples `start`.
- Latency: `out_valid` and `parallel_out` update on the same edge that samples the last bit; the word is visible in the next cycle. There is no extra pipeline stage.
- Simultaneous events:
  - `abort` together with a completing bit: abort wins, no word is produced and `overrun` does not change.
  - `start` in SHIFT is ignored.
  - `start` and `abort` together in IDLE: `abort` wins and the FSM stays in IDLE.
- Back-to-back words with `continuous`=1 and `serial_valid` held high: one word every DATA_WIDTH cycles with no bubble. With `out_ready` held high, no overrun occurs.
- `bit_count` wrap: it never reaches DATA_WIDTH; it wraps from DATA_WIDTH-1 to 0 at completion.

## Test plan
- Single word (DATA_WIDTH=8, `continuous`=0): pulse `start`, then bits 1,0,1,1,0,0,1,0 on consecutive cycles -> `parallel_out`=8'hB2 and `out_valid`=1 in the cycle after the 8th bit. `busy` drops on the same edge. `out_ready`=1 clears `out_valid`.
- Gapped input: same bits as above, with `serial_valid` low for 3 cycles between bits 4 and 5 -> `bit_count` holds at 4 during the gap, result is 8'hB2.
- Overrun (`continuous`=1, `out_ready`=0): send 8'hA5 then 8'h3C -> `parallel_out`=8'hA5 and `overrun`=1 after the second word. Pulse `clear_overrun` -> `overrun`=0. Set `out_ready`=1 -> one transfer of 8'hA5.
- Drain/complete collision: `out_valid`=1 holding 8'h11, assert `out_ready` on the completing-bit cycle of 8'h22 -> `out_valid` stays 1, `parallel_out`=8'h22, `overrun`=0.
- Abort mid-word: after 5 bits of 8'hFF, assert `abort` -> IDLE, `bit_count`=0, no `out_valid`. Then `start` and 8'h0F -> output exactly 8'h0F.
- Reset mid-operation: assert `reset` after 3 bits with a word buffered -> all outputs return to reset values the next cycle. The next frame with 8'hC3 completes correctly.
